// File: rtl/ad936x_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ad936x_spi_ctrl
// Brief    : Two-port register-access controller for the AD936x 4-wire SPI
//            port and hardware reset pin. Arbitrates port A (I2C bridge) and
//            port B (local sequencer), serialises 24-bit single-byte frames
//            and returns read data with a req/ack handshake.
// Options  : define AD936X_SPI_RR_ARB_EN for round-robin arbitration;
//            otherwise port A has fixed priority on simultaneous requests.
// Revision : 1.0 - initial release
// ============================================================================
module ad936x_spi_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int RESET_HOLD = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a_req,
    input  logic       a_write,
    input  logic [9:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_write,
    input  logic [9:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic       nspi_enb,
    output logic       spi_clk,
    output logic       spi_di,
    input  logic       spi_do,
    output logic       nresetb,
    output logic       ready,
    output logic       busy
);

    // LOAD is the cycle between the grant edge and chip-enable assertion.
    localparam logic [2:0] c_HOLD    = 3'd0;
    localparam logic [2:0] c_IDLE    = 3'd1;
    localparam logic [2:0] c_LOAD    = 3'd2;
    localparam logic [2:0] c_SETUP   = 3'd3;
    localparam logic [2:0] c_SHIFT   = 3'd4;
    localparam logic [2:0] c_HOLDOFF = 3'd5;
    localparam logic [2:0] c_GAP     = 3'd6;
    localparam logic [2:0] c_ACK     = 3'd7;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_cnt;        // clocks spent in the current state / half-period
    logic        r_phase;      // SHIFT only: 0 = low half, 1 = high half
    logic [4:0]  r_bit;        // SHIFT only: bits fully transferred
    logic [23:0] r_shift;
    logic [7:0]  r_rx;
    logic        r_sel_b;
    logic        r_write;

    logic        w_any_req;
    logic        w_pick_b;
    logic        w_hold_done;
    logic        w_div_done;
    logic        w_high_end;
    logic        w_pick_write;
    logic [9:0]  w_pick_addr;
    logic [7:0]  w_pick_wdata;

    assign w_any_req   = a_req | b_req;
    assign w_hold_done = (r_cnt == 32'(RESET_HOLD - 1));
    assign w_div_done  = (r_cnt == 32'(CLK_DIV - 1));
    assign w_high_end  = r_phase & w_div_done;

`ifdef AD936X_SPI_RR_ARB_EN
    logic r_rr_ptr;            // 0 = A wins the next tie, 1 = B wins

    assign w_pick_b = b_req & (~a_req | r_rr_ptr);

    // Flip the tie-break owner whenever a tie is actually resolved.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (r_state == c_IDLE && a_req && b_req) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end
`else
    assign w_pick_b = b_req & ~a_req;
`endif

    assign w_pick_write = w_pick_b ? b_write : a_write;
    assign w_pick_addr  = w_pick_b ? b_addr  : a_addr;
    assign w_pick_wdata = w_pick_b ? b_wdata : a_wdata;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_HOLD:    if (w_hold_done) w_next_state = c_IDLE;
            c_IDLE:    if (w_any_req) w_next_state = c_LOAD;
            c_LOAD:    w_next_state = c_SETUP;
            c_SETUP:   if (w_div_done) w_next_state = c_SHIFT;
            c_SHIFT:   if (w_high_end && r_bit == 5'd23) w_next_state = c_HOLDOFF;
            c_HOLDOFF: if (w_div_done) w_next_state = c_GAP;
            c_GAP:     if (w_div_done) w_next_state = c_ACK;
            c_ACK:     w_next_state = c_IDLE;
            default:   w_next_state = c_HOLD;
        endcase
    end

    // Output decode; every pin is a function of state and datapath registers.
    always_comb begin
        nspi_enb = ~(r_state == c_SETUP || r_state == c_SHIFT || r_state == c_HOLDOFF);
        spi_clk  = (r_state == c_SHIFT) & r_phase;
        spi_di   = (r_state == c_SETUP || r_state == c_SHIFT) ? r_shift[23] : 1'b0;
        a_ack    = (r_state == c_ACK) & ~r_sel_b;
        b_ack    = (r_state == c_ACK) & r_sel_b;
        nresetb  = (r_state != c_HOLD);
        ready    = (r_state != c_HOLD);
        busy     = (r_state == c_SETUP) || (r_state == c_SHIFT) || (r_state == c_HOLDOFF)
                || (r_state == c_GAP) || (r_state == c_ACK);
    end

    // Timing counter: restarts on every state change and every SPI half-period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state != w_next_state || (r_state == c_SHIFT && w_div_done)) begin
            r_cnt <= '0;
        end else if (r_state != c_IDLE) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Half-period phase and bit index within the SHIFT state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else if (r_state != c_SHIFT) begin
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else if (w_div_done) begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                r_bit <= r_bit + 5'd1;
            end
        end
    end

    // Grant capture and serial shift: MISO sampled and MOSI advanced at the
    // last clock of each high half, so the next bit appears as SCLK falls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_rx    <= '0;
            r_sel_b <= 1'b0;
            r_write <= 1'b0;
        end else if (r_state == c_IDLE && w_any_req) begin
            r_sel_b <= w_pick_b;
            r_write <= w_pick_write;
            r_shift <= {w_pick_write, 3'b000, 2'b00, w_pick_addr,
                        w_pick_write ? w_pick_wdata : 8'h00};
        end else if (r_state == c_SHIFT && w_high_end) begin
            r_shift <= {r_shift[22:0], 1'b0};
            r_rx    <= {r_rx[6:0], spi_do};
        end
    end

    // Read data lands as ACK is entered so it is valid alongside the ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_rdata <= 8'h00;
            b_rdata <= 8'h00;
        end else if (r_state == c_GAP && w_div_done && !r_write) begin
            if (r_sel_b) begin
                b_rdata <= r_rx;
            end else begin
                a_rdata <= r_rx;
            end
        end
    end

endmodule
`default_nettype wire
